// File: rtl/iob_ibex_clint_if.sv
// IOB control-bus bundle between the Ibex SoC interconnect and the CLINT.
// master drives the request; slave returns ready and read data.
interface iob_ibex_clint_if #(
   parameter int unsigned ADDR_W = 14,
   parameter int unsigned DATA_W = 32
);
   logic              iob_valid;
   logic [ADDR_W-1:0] iob_addr;
   logic [DATA_W-1:0] iob_wdata;
   logic [3:0]        iob_wstrb;
   logic              iob_rvalid;
   logic [DATA_W-1:0] iob_rdata;
   logic              iob_ready;

   modport master (
      output iob_valid, iob_addr, iob_wdata, iob_wstrb,
      input  iob_rvalid, iob_rdata, iob_ready
   );

   modport slave (
      input  iob_valid, iob_addr, iob_wdata, iob_wstrb,
      output iob_rvalid, iob_rdata, iob_ready
   );
endinterface

// File: rtl/iob_ibex_clint.sv
// Core-local interruptor for the Ibex hart: 64-bit mtime/mtimecmp, msip, IOB register access.
// Optional mtime prescaler enabled by defining IOB_IBEX_CLINT_PRESCALER_EN.
module iob_ibex_clint #(
   parameter int unsigned CLK_DIV = 1,
   parameter int unsigned ADDR_W  = 14,
   parameter int unsigned DATA_W  = 32
) (
   input  logic                   clk_i,
   input  logic                   cke_i,
   input  logic                   arst_ni,
   iob_ibex_clint_if.slave        iob,
   output logic                   irq_timer_o,
   output logic                   irq_software_o
);

   if ((CLK_DIV == 0) || (CLK_DIV > 65535) || (DATA_W != 32)) begin : gen_param_check
      $error("iob_ibex_clint: CLK_DIV must be 1..65535 and DATA_W must be 32");
   end

   localparam logic [ADDR_W-1:0] AddrMsip   = '0;
   localparam logic [ADDR_W-1:0] AddrCmpLo  = ADDR_W'(32'h2000);
   localparam logic [ADDR_W-1:0] AddrCmpHi  = ADDR_W'(32'h2004);
   localparam logic [ADDR_W-1:0] AddrTimeLo = ADDR_W'(32'h3FF8);
   localparam logic [ADDR_W-1:0] AddrTimeHi = ADDR_W'(32'h3FFC);

   logic              ready_q, rvalid_q, irq_timer_q;
   logic              msip_q, msip_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [63:0]       mtime_q, mtime_d, mtime_tick;
   logic [63:0]       mtimecmp_q, mtimecmp_d;
   logic [ADDR_W-1:0] word_addr;
   logic              sel_msip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi;
   logic              accept, wr, rd, tick, time_wr;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
      end
      return res;
   endfunction

   assign word_addr   = iob.iob_addr & ~ADDR_W'(3);
   assign sel_msip    = (word_addr == AddrMsip);
   assign sel_cmp_lo  = (word_addr == AddrCmpLo);
   assign sel_cmp_hi  = (word_addr == AddrCmpHi);
   assign sel_time_lo = (word_addr == AddrTimeLo);
   assign sel_time_hi = (word_addr == AddrTimeHi);

   assign accept  = iob.iob_valid & ready_q & cke_i;
   assign wr      = accept & (|iob.iob_wstrb);
   assign rd      = accept & ~(|iob.iob_wstrb);
   assign time_wr = wr & (sel_time_lo | sel_time_hi);

`ifdef IOB_IBEX_CLINT_PRESCALER_EN
   localparam logic [15:0] PrescMax = 16'(CLK_DIV - 1);

   logic [15:0] presc_q, presc_d;

   // Tick on the cycle the prescaler wraps back to zero.
   assign tick = cke_i & (presc_q == PrescMax);

   always_comb begin
      presc_d = (presc_q == PrescMax) ? 16'd0 : presc_q + 16'd1;
      if (time_wr) presc_d = 16'd0;
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         presc_q <= 16'd0;
      end else if (cke_i) begin
         presc_q <= presc_d;
      end
   end
`else
   assign tick = cke_i;
`endif

   always_comb begin
      mtime_tick = mtime_q + {63'd0, tick};
      mtime_d    = mtime_tick;
      mtimecmp_d = mtimecmp_q;
      msip_d     = msip_q;
      rdata_d    = rdata_q;
      // Unwritten MTIME bytes keep the ticked value; no carry from a low-word write.
      if (wr) begin
         if (sel_msip && iob.iob_wstrb[0]) msip_d = iob.iob_wdata[0];
         if (sel_cmp_lo)
            mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], iob.iob_wdata, iob.iob_wstrb);
         if (sel_cmp_hi)
            mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], iob.iob_wdata, iob.iob_wstrb);
         if (sel_time_lo)
            mtime_d[31:0] = merge_bytes(mtime_tick[31:0], iob.iob_wdata, iob.iob_wstrb);
         if (sel_time_hi)
            mtime_d[63:32] = merge_bytes(mtime_tick[63:32], iob.iob_wdata, iob.iob_wstrb);
      end
      if (rd) begin
         if (sel_msip)         rdata_d = {31'd0, msip_q};
         else if (sel_cmp_lo)  rdata_d = mtimecmp_q[31:0];
         else if (sel_cmp_hi)  rdata_d = mtimecmp_q[63:32];
         else if (sel_time_lo) rdata_d = mtime_q[31:0];
         else if (sel_time_hi) rdata_d = mtime_q[63:32];
         else                  rdata_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         ready_q     <= 1'b0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
         mtime_q     <= 64'd0;
         mtimecmp_q  <= '1;
         msip_q      <= 1'b0;
         irq_timer_q <= 1'b0;
      end else if (cke_i) begin
         ready_q     <= 1'b1;
         rvalid_q    <= rd;
         rdata_q     <= rdata_d;
         mtime_q     <= mtime_d;
         mtimecmp_q  <= mtimecmp_d;
         msip_q      <= msip_d;
         irq_timer_q <= (mtime_q >= mtimecmp_q);
      end
   end

   assign iob.iob_ready  = ready_q;
   assign iob.iob_rvalid = rvalid_q;
   assign iob.iob_rdata  = rdata_q;
   assign irq_timer_o    = irq_timer_q;
   assign irq_software_o = msip_q;

endmodule
